// File: rtl/multi_da_dds.sv
// Multi-channel DDS feeding parallel DACs.
// Each channel has a phase accumulator, a phase offset, an external synchronous
// waveform ROM, and an amplitude scaler. Configuration is written into shadow
// registers, and a global update pulse moves it into the active registers.
module multi_da_dds #(
  parameter int CH  = 2,
  parameter int CHW = 1,
  parameter int DW  = 10,
  parameter int AW  = 10,
  parameter int PW  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic             cfg_en,
  input  logic [PW-1:0]    cfg_ftw,
  input  logic [PW-1:0]    cfg_phase,
  input  logic [8:0]       cfg_amp,
  input  logic             cfg_update,
  input  logic             cfg_phase_rst,
  output logic             cfg_err,
  output logic [CH*AW-1:0] rom_addr,
  input  logic [CH*DW-1:0] rom_data,
  output logic             da_clk,
  output logic [CH*DW-1:0] da_data
);

  localparam logic [CHW:0]  CH_LIM = (CHW+1)'(CH);
  localparam logic [DW-1:0] MID    = {1'b1, {(DW-1){1'b0}}};

  // Amplitude above unity is clamped so the scaled sample cannot overflow.
  function automatic logic [8:0] sat_amp(input logic [8:0] amp);
    return (amp > 9'd256) ? 9'd256 : amp;
  endfunction

  // The offset-binary sample is converted to signed, multiplied by the
  // amplitude, and shifted arithmetically (floor). The result is then
  // converted back to offset binary.
  function automatic logic [DW-1:0] scale_sample(input logic [DW-1:0] raw,
                                                 input logic [8:0]    amp);
    logic signed [DW-1:0] s;
    logic signed [9:0]    a;
    s = signed'(raw ^ MID);
    a = signed'({1'b0, sat_amp(amp)});
    return DW'(((DW+10)'(s) * (DW+10)'(a)) >>> 8) ^ MID;
  endfunction

  // Top AW bits of the offset phase, with modulo-2^PW wrap.
  function automatic logic [AW-1:0] phase_to_addr(input logic [PW-1:0] acc_v,
                                                  input logic [PW-1:0] ofs);
    return AW'((acc_v + ofs) >> (PW - AW));
  endfunction

  logic          shd_en    [CH];
  logic [PW-1:0] shd_ftw   [CH];
  logic [PW-1:0] shd_phase [CH];
  logic [8:0]    shd_amp   [CH];
  logic          act_en    [CH];
  logic [PW-1:0] act_ftw   [CH];
  logic [PW-1:0] act_phase [CH];
  logic [8:0]    act_amp   [CH];
  logic [PW-1:0] acc       [CH];
  logic [AW-1:0] addr_p0   [CH];
  logic [8:0]    amp_p0    [CH];
  logic [8:0]    amp_p1    [CH];
  logic          vld_p0    [CH];
  logic          vld_p1    [CH];
  logic [DW-1:0] da_p2     [CH];

  logic wr_acc;
  logic wr_bad;

  assign wr_acc = cfg_valid && cfg_ready;
  assign wr_bad = ({1'b0, cfg_ch} >= CH_LIM);
  assign da_clk = ~clk;

  // Config handshake, shadow writes, and the global shadow-to-active copy.
  // A write never reaches the active registers in the same edge, so an
  // update that coincides with a write applies the old shadow value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        shd_en[c]    <= 1'b0;
        shd_ftw[c]   <= '0;
        shd_phase[c] <= '0;
        shd_amp[c]   <= '0;
        act_en[c]    <= 1'b0;
        act_ftw[c]   <= '0;
        act_phase[c] <= '0;
        act_amp[c]   <= '0;
      end
    end else begin
      cfg_ready <= !wr_acc;
      if (wr_acc && wr_bad)
        cfg_err <= 1'b1;
      for (int c = 0; c < CH; c++) begin
        if (wr_acc && (cfg_ch == CHW'(c))) begin
          shd_en[c]    <= cfg_en;
          shd_ftw[c]   <= cfg_ftw;
          shd_phase[c] <= cfg_phase;
          shd_amp[c]   <= cfg_amp;
        end
        if (cfg_update) begin
          act_en[c]    <= shd_en[c];
          act_ftw[c]   <= shd_ftw[c];
          act_phase[c] <= shd_phase[c];
          act_amp[c]   <= shd_amp[c];
        end
      end
    end
  end

  // Phase accumulators. A global phase reset takes priority over
  // accumulation, and a disabled channel is held at zero.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (!rst_n || (cfg_update && cfg_phase_rst) || !act_en[c])
        acc[c] <= '0;
      else
        acc[c] <= acc[c] + act_ftw[c];
    end
  end

  // Stage p0: ROM address. Stage p1: ROM read. Stage p2: scaled DAC word.
  // The enable and amplitude travel with the sample to its output.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (!rst_n) begin
        addr_p0[c] <= '0;
        vld_p0[c]  <= 1'b0;
        amp_p0[c]  <= '0;
        vld_p1[c]  <= 1'b0;
        amp_p1[c]  <= '0;
        da_p2[c]   <= MID;
      end else begin
        addr_p0[c] <= phase_to_addr(acc[c], act_phase[c]);
        vld_p0[c]  <= act_en[c];
        amp_p0[c]  <= act_amp[c];
        vld_p1[c]  <= vld_p0[c];
        amp_p1[c]  <= amp_p0[c];
        da_p2[c]   <= vld_p1[c] ? scale_sample(rom_data[c*DW +: DW], amp_p1[c]) : MID;
      end
    end
  end

  // Pack the per-channel registers onto the flat output buses.
  always_comb begin
    rom_addr = '0;
    da_data  = '0;
    for (int c = 0; c < CH; c++) begin
      rom_addr[c*AW +: AW] = addr_p0[c];
      da_data[c*DW +: DW]  = da_p2[c];
    end
  end

endmodule

// File: tb/tb_multi_da_dds.sv
// Directed self-checking bench for multi_da_dds.
// The main instance uses CH=2. A second instance with CH=1 exercises the
// out-of-range channel error.
module tb_multi_da_dds;

  localparam int DW = 10;
  localparam int AW = 10;
  localparam int PW = 32;
  localparam logic [31:0] FTW_STEP = 32'h0040_0000;
  localparam logic [31:0] PH_HALF  = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            cfg_valid, cfg_ready, cfg_en, cfg_update, cfg_phase_rst, cfg_err, da_clk;
  logic [0:0]      cfg_ch;
  logic [PW-1:0]   cfg_ftw, cfg_phase;
  logic [8:0]      cfg_amp;
  logic [2*AW-1:0] rom_addr;
  logic [2*DW-1:0] rom_data, da_data;

  logic            cfg_valid1, cfg_update1, cfg_ready1, cfg_err1, da_clk1;
  logic [AW-1:0]   rom_addr1;
  logic [DW-1:0]   rom_data1, da_data1;

  logic            rom_mode;
  logic [DW-1:0]   rom_force;

  int n_tests = 0;
  int n_fail  = 0;

  multi_da_dds #(.CH(2), .CHW(1), .DW(DW), .AW(AW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase),
    .cfg_amp(cfg_amp), .cfg_update(cfg_update), .cfg_phase_rst(cfg_phase_rst),
    .cfg_err(cfg_err), .rom_addr(rom_addr), .rom_data(rom_data),
    .da_clk(da_clk), .da_data(da_data)
  );

  multi_da_dds #(.CH(1), .CHW(1), .DW(DW), .AW(AW), .PW(PW)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
    .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase),
    .cfg_amp(cfg_amp), .cfg_update(cfg_update1), .cfg_phase_rst(cfg_phase_rst),
    .cfg_err(cfg_err1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .da_clk(da_clk1), .da_data(da_data1)
  );

  // Synchronous ROM models: identity (data = address) or a forced constant.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      rom_data[c*DW +: DW] <= rom_mode ? rom_force : rom_addr[c*AW +: AW];
    rom_data1 <= rom_addr1;
  end

  function automatic logic [DW-1:0] da(input int c);
    return da_data[c*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] ra(input int c);
    return rom_addr[c*AW +: AW];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_write(input logic ch, input logic en, input logic [31:0] ftw,
                           input logic [31:0] ph, input logic [8:0] amp);
    int waited;
    waited = 0;
    while (!cfg_ready && waited < 8) begin
      tick();
      waited++;
    end
    check_eq("wr_ready", 32'(cfg_ready), 32'd1);
    cfg_ch = ch; cfg_en = en; cfg_ftw = ftw; cfg_phase = ph; cfg_amp = amp;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_update(input logic prst);
    cfg_update = 1'b1;
    cfg_phase_rst = prst;
    tick();
    cfg_update = 1'b0;
    cfg_phase_rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_update = 1'b0; cfg_phase_rst = 1'b0;
    cfg_ch = 1'b0; cfg_en = 1'b0; cfg_ftw = '0; cfg_phase = '0; cfg_amp = '0;
    cfg_valid1 = 1'b0; cfg_update1 = 1'b0; rom_mode = 1'b0; rom_force = '0;

    // Reset state
    ticks(3);
    check_eq("rst_da0", 32'(da(0)), 32'd512);
    check_eq("rst_da1", 32'(da(1)), 32'd512);
    check_eq("rst_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_err", 32'(cfg_err), 32'd0);
    check_eq("rst_da_b", 32'(da_data1), 32'd512);
    rst_n = 1'b1;
    ticks(2);
    check_eq("idle_da0", 32'(da(0)), 32'd512);
    check_eq("idle_da1", 32'(da(1)), 32'd512);
    check_eq("idle_ready", 32'(cfg_ready), 32'd1);
    check_eq("idle_err", 32'(cfg_err), 32'd0);

    // Ch0 sweep: one ROM step per cycle, 3-cycle latency to da_data, wrap
    cfg_write(1'b0, 1'b1, FTW_STEP, 32'd0, 9'd256);
    check_eq("ready_low", 32'(cfg_ready), 32'd0);
    do_update(1'b1);
    for (int n = 1; n <= 1030; n++) begin
      tick();
      check_eq("sweep_addr0", 32'(ra(0)), 32'((n - 1) % 1024));
      if (n >= 3) check_eq("sweep_da0", 32'(da(0)), 32'((n - 3) % 1024));
      else        check_eq("sweep_da0_mid", 32'(da(0)), 32'd512);
      if (n < 5) begin
        check_eq("sweep_da1_mid", 32'(da(1)), 32'd512);
        check_eq("sweep_addr1", 32'(ra(1)), 32'd0);
      end
    end

    // Ch1 half-cycle phase offset, both channels restarted together
    cfg_write(1'b1, 1'b1, FTW_STEP, PH_HALF, 9'd256);
    do_update(1'b1);
    for (int n = 1; n <= 8; n++) begin
      logic [AW-1:0] diff;
      tick();
      diff = ra(1) - ra(0);
      check_eq("ofs_addr0", 32'(ra(0)), 32'(n - 1));
      check_eq("ofs_addr1", 32'(ra(1)), 32'((n - 1 + 512) % 1024));
      check_eq("ofs_diff", 32'(diff), 32'd512);
    end

    // A write coincident with update lands only in the shadow register
    rom_mode = 1'b1; rom_force = 10'd1023;
    cfg_ch = 1'b1; cfg_en = 1'b1; cfg_ftw = FTW_STEP; cfg_phase = PH_HALF; cfg_amp = 9'd128;
    cfg_valid = 1'b1; cfg_update = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_update = 1'b0;
    ticks(5);
    check_eq("coinc_old_amp", 32'(da(1)), 32'd1023);
    check_eq("coinc_da0", 32'(da(0)), 32'd1023);
    do_update(1'b0);
    ticks(4);
    check_eq("coinc_new_amp", 32'(da(1)), 32'd767);

    // Amplitude scaling on ch0
    cfg_write(1'b0, 1'b1, FTW_STEP, 32'd0, 9'd128);
    do_update(1'b0);
    ticks(4);
    check_eq("amp128_hi", 32'(da(0)), 32'd767);
    rom_force = 10'd0;
    ticks(3);
    check_eq("amp128_lo", 32'(da(0)), 32'd256);
    cfg_write(1'b0, 1'b1, FTW_STEP, 32'd0, 9'd0);
    do_update(1'b0);
    ticks(4);
    check_eq("amp0_lo", 32'(da(0)), 32'd512);
    rom_force = 10'd1023;
    ticks(3);
    check_eq("amp0_hi", 32'(da(0)), 32'd512);
    cfg_write(1'b0, 1'b1, FTW_STEP, 32'd0, 9'd300);
    do_update(1'b0);
    ticks(4);
    check_eq("amp300_hi", 32'(da(0)), 32'd1023);
    rom_force = 10'd0;
    ticks(3);
    check_eq("amp300_lo", 32'(da(0)), 32'd0);
    rom_force = 10'd700;
    ticks(3);
    check_eq("amp300_mid", 32'(da(0)), 32'd700);

    // Disabling ch0 forces midscale after the pipeline drains
    rom_force = 10'd1023;
    ticks(3);
    cfg_write(1'b0, 1'b0, 32'd0, 32'd0, 9'd300);
    do_update(1'b0);
    tick();
    check_eq("dis_d1", 32'(da(0)), 32'd1023);
    tick();
    check_eq("dis_d2", 32'(da(0)), 32'd1023);
    tick();
    check_eq("dis_d3", 32'(da(0)), 32'd512);
    check_eq("dis_addr", 32'(ra(0)), 32'd0);

    // Back-to-back requests: ready goes 1,0,1,0
    check_eq("b2b_r0", 32'(cfg_ready), 32'd1);
    cfg_ch = 1'b1; cfg_en = 1'b1; cfg_ftw = FTW_STEP; cfg_phase = PH_HALF; cfg_amp = 9'd256;
    cfg_valid = 1'b1;
    tick();
    check_eq("b2b_r1", 32'(cfg_ready), 32'd0);
    tick();
    check_eq("b2b_r2", 32'(cfg_ready), 32'd1);
    tick();
    check_eq("b2b_r3", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    tick();
    check_eq("b2b_r4", 32'(cfg_ready), 32'd1);

    // Out-of-range channel on the CH=1 instance
    check_eq("err_before", 32'(cfg_err1), 32'd0);
    cfg_ch = 1'b1; cfg_en = 1'b1; cfg_ftw = FTW_STEP; cfg_phase = PH_HALF; cfg_amp = 9'd256;
    cfg_valid1 = 1'b1;
    tick();
    cfg_valid1 = 1'b0;
    check_eq("err_set", 32'(cfg_err1), 32'd1);
    check_eq("err_ready", 32'(cfg_ready1), 32'd0);
    cfg_update1 = 1'b1; cfg_phase_rst = 1'b1;
    tick();
    cfg_update1 = 1'b0; cfg_phase_rst = 1'b0;
    ticks(4);
    check_eq("err_addr", 32'(rom_addr1), 32'd0);
    check_eq("err_da", 32'(da_data1), 32'd512);
    check_eq("err_sticky", 32'(cfg_err1), 32'd1);
    check_eq("err_main", 32'(cfg_err), 32'd0);

    // Mid-run reset with a write and an update in flight
    cfg_ch = 1'b0; cfg_en = 1'b1; cfg_ftw = FTW_STEP; cfg_phase = 32'd0; cfg_amp = 9'd256;
    rst_n = 1'b0; cfg_valid = 1'b1; cfg_update = 1'b1;
    tick();
    check_eq("mrst_da0", 32'(da(0)), 32'd512);
    check_eq("mrst_da1", 32'(da(1)), 32'd512);
    check_eq("mrst_addr", 32'(rom_addr), 32'd0);
    check_eq("mrst_ready", 32'(cfg_ready), 32'd1);
    check_eq("mrst_err", 32'(cfg_err), 32'd0);
    check_eq("mrst_err_b", 32'(cfg_err1), 32'd0);
    rst_n = 1'b1; cfg_valid = 1'b0; cfg_update = 1'b0;
    tick();
    do_update(1'b0);
    ticks(5);
    check_eq("mrst_addr0", 32'(ra(0)), 32'd0);
    check_eq("mrst_addr1", 32'(ra(1)), 32'd0);
    check_eq("mrst_da0_after", 32'(da(0)), 32'd512);
    check_eq("mrst_da1_after", 32'(da(1)), 32'd512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
